// File: rtl/tlv5638_pkg.sv
// tlv5638_pkg: shared types and constants for the TLV5638 DAC transmitter.
// Holds the sequencer state enum, serializer phases and frame word helper.
package tlv5638_pkg;

  typedef enum logic [1:0] {
    ST_INIT_CTRL,
    ST_IDLE,
    ST_FRAME_B,
    ST_FRAME_A
  } tx_state_e;

  // Serializer phases: LEAD = half 0, LOW = odd halves,
  // HIGH = even halves 2..30, TAIL = half 32, GAP = half 33.
  typedef enum logic [2:0] {
    PH_LEAD,
    PH_LOW,
    PH_HIGH,
    PH_TAIL,
    PH_GAP
  } ph_e;

  // R1:R0 register selects
  localparam logic [1:0] RS_CTRL = 2'b11;
  localparam logic [1:0] RS_BUF  = 2'b01;
  localparam logic [1:0] RS_DACA = 2'b10;

  localparam int FRAME_HALVES = 34;

  // Frame word: {R1, SPD, PWR=0, R0, payload}
  function automatic logic [15:0] mk_word(
    input logic [1:0]  rs,
    input logic        spd,
    input logic [11:0] pay
  );
    return {rs[1], spd, 1'b0, rs[0], pay};
  endfunction

endpackage

// File: rtl/tlv5638_tx_ser.sv
// dac_frame_ser: shifts one 16-bit word out as a TLV5638 frame.
// Ports: clk, rst, start, word in; cs_n, sclk, din, done, active out.
module dac_frame_ser
  import tlv5638_pkg::*;
#(
  parameter int SCLK_HALF = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] word,
  output logic        cs_n,
  output logic        sclk,
  output logic        din,
  output logic        done,
  output logic        active
);

  localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(SCLK_HALF - 1);

  logic          active_q, active_d;
  ph_e           ph_q, ph_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [15:0]   sh_q, sh_d;
  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic          din_q, din_d;

  logic       step;
  logic       last;
  logic       load;
  logic [3:0] nxt_bit;

  assign step    = active_q && (cyc_q == CYC_LAST);
  assign last    = step && (ph_q == PH_GAP);
  // A new frame may start in the final cycle of the previous one,
  // which lets two frames run back to back.
  assign load    = start && (!active_q || last);
  assign nxt_bit = bit_q + 4'd1;

  always_comb begin
    active_d = active_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    cyc_d    = cyc_q;
    sh_d     = sh_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    din_d    = din_q;
    if (active_q) begin
      cyc_d = step ? '0 : cyc_q + 1'b1;
    end
    if (step) begin
      unique case (ph_q)
        PH_LEAD: begin
          ph_d   = PH_LOW;
          sclk_d = 1'b0;
        end
        PH_LOW: begin
          sclk_d = 1'b1;
          if (bit_q == 4'd15) begin
            ph_d = PH_TAIL;
          end else begin
            ph_d  = PH_HIGH;
            bit_d = nxt_bit;
            din_d = sh_q[~nxt_bit];
          end
        end
        PH_HIGH: begin
          ph_d   = PH_LOW;
          sclk_d = 1'b0;
        end
        PH_TAIL: begin
          ph_d   = PH_GAP;
          cs_n_d = 1'b1;
          din_d  = 1'b0;
        end
        PH_GAP: begin
          active_d = 1'b0;
        end
        default: begin
          active_d = 1'b0;
        end
      endcase
    end
    if (load) begin
      active_d = 1'b1;
      ph_d     = PH_LEAD;
      bit_d    = 4'd0;
      cyc_d    = '0;
      sh_d     = word;
      cs_n_d   = 1'b0;
      sclk_d   = 1'b1;
      din_d    = word[15];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      ph_q     <= PH_LEAD;
      bit_q    <= 4'd0;
      cyc_q    <= '0;
      sh_q     <= 16'd0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b1;
      din_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      cyc_q    <= cyc_d;
      sh_q     <= sh_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      din_q    <= din_d;
    end
  end

  assign cs_n   = cs_n_q;
  assign sclk   = sclk_q;
  assign din    = din_q;
  assign done   = last;
  assign active = active_q;

endmodule

// File: rtl/tlv5638_tx.sv
// tlv5638_tx: programs the TLV5638 once, then sends B/A frame pairs per tick.
// Ports: clk, rst, sample_tick, data_a/b in; dac_cs_n/sclk/din, busy, init_done, overrun out.
module tlv5638_tx
  import tlv5638_pkg::*;
#(
  parameter int         SCLK_HALF = 2,
  parameter logic       SPD       = 1'b1,
  parameter logic [1:0] REF_SEL   = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tick,
  input  logic [11:0] data_a,
  input  logic [11:0] data_b,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_din,
  output logic        busy,
  output logic        init_done,
  output logic        overrun
);

  tx_state_e   state_q, state_d;
  logic [11:0] hold_a_q, hold_a_d;
  logic [11:0] hold_b_q, hold_b_d;
  logic        init_done_q, init_done_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;

  logic        ser_start;
  logic [15:0] ser_word;
  logic        ser_done;
  logic        ser_active;

  logic [15:0] ctrl_word;
  logic [15:0] buf_word;
  logic [15:0] daca_word;

  assign ctrl_word = mk_word(RS_CTRL, SPD, {10'd0, REF_SEL});
  assign buf_word  = mk_word(RS_BUF, SPD, hold_b_q);
  assign daca_word = mk_word(RS_DACA, SPD, hold_a_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT_CTRL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT_CTRL: if (ser_done)    state_d = ST_IDLE;
      ST_IDLE:      if (sample_tick) state_d = ST_FRAME_B;
      ST_FRAME_B:   if (ser_done)    state_d = ST_FRAME_A;
      ST_FRAME_A:   if (ser_done)    state_d = ST_IDLE;
      default:                       state_d = ST_INIT_CTRL;
    endcase
  end

  always_comb begin
    ser_start = 1'b0;
    ser_word  = ctrl_word;
    hold_a_d  = hold_a_q;
    hold_b_d  = hold_b_q;
    unique case (state_q)
      ST_INIT_CTRL: begin
        ser_start = !ser_active;
      end
      ST_FRAME_B: begin
        // First cycle launches BUF; the done cycle chains DACA.
        ser_start = !ser_active || ser_done;
        ser_word  = ser_active ? daca_word : buf_word;
      end
      default: begin
        ser_start = 1'b0;
      end
    endcase
    if (state_q == ST_IDLE && sample_tick) begin
      hold_a_d = data_a;
      hold_b_d = data_b;
    end
    overrun_d   = sample_tick && (state_q != ST_IDLE);
    init_done_d = init_done_q
                  || (state_q == ST_INIT_CTRL && ser_done);
    // Rises with cs_n on a data sequence, drops as the FSM idles.
    busy_d      = (state_q != ST_IDLE) && (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_a_q    <= 12'd0;
      hold_b_q    <= 12'd0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      hold_a_q    <= hold_a_d;
      hold_b_q    <= hold_b_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  dac_frame_ser #(
    .SCLK_HALF(SCLK_HALF)
  ) u_ser (
    .clk   (clk),
    .rst   (rst),
    .start (ser_start),
    .word  (ser_word),
    .cs_n  (dac_cs_n),
    .sclk  (dac_sclk),
    .din   (dac_din),
    .done  (ser_done),
    .active(ser_active)
  );

  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign overrun   = overrun_q;

endmodule
